instr_fetch_assembler: RTL and testbench

//  Parametrised fetch front end for the multicycle MIPS core. Fetches instructions from a narrow

---
 rtl/ifa_pkg.sv | 21 ++
 rtl/ifa_fifo.sv | 60 ++++++
 rtl/instr_fetch_assembler.sv | 117 +++++++++++
 tb/tb_instr_fetch_assembler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ifa_pkg.sv
// Shared types and helpers for the instruction fetch assembler.
// Build option: IFA_BIG_ENDIAN_EN selects MSB-first beat placement (see instr_fetch_assembler).
package ifa_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

    // Beat counter width; a 1-beat instruction still needs a 1-bit index.
    function automatic int beat_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Byte-address increment per memory beat and per whole instruction.
    function automatic int beat_step(input int mem_w);
        return mem_w / 8;
    endfunction

    function automatic int instr_step(input int instr_w);
        return instr_w / 8;
    endfunction

endpackage

// File: rtl/ifa_fifo.sv
// Instruction buffer: DEPTH-entry synchronous FIFO with flush, occupancy count and
// a head output that reads zero while empty.
module ifa_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SLOTS = 2 ** PW;

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    // A full buffer can still take a push when the head leaves on the same edge.
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign dout    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_assembler.sv
// Fetch front end: assembles MEM_W beats into INSTR_W words and queues them with their PC.
// Build option: IFA_BIG_ENDIAN_EN places the first beat in the MSBs (default: LSBs).
module instr_fetch_assembler
    import ifa_pkg::*;
#(
    parameter int                MEM_W    = 8,
    parameter int                INSTR_W  = 32,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_adr,
    input  logic                        mem_ack,
    input  logic [MEM_W-1:0]            memdata,
    output logic [INSTR_W/MEM_W-1:0]    irwrite,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [INSTR_W-1:0]          instr,
    output logic [ADDR_W-1:0]           instr_pc,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int                BEATS = INSTR_W / MEM_W;
    localparam int                BW    = beat_idx_w(BEATS);
    localparam int                CW    = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(beat_step(MEM_W));

    state_t               state, state_nxt;
    logic [BW-1:0]        beat, slot;
    logic [INSTR_W-1:0]   asm_word, word_nxt;
    logic [ADDR_W-1:0]    start_pc, push_pc;
    logic                 take, last, push, pop, room;
    logic [CW:0]          cnt_after;

    // A redirect edge discards whatever beat is acknowledged alongside it.
    assign take    = mem_req && mem_ack && !redirect;
    assign last    = (beat == BW'(BEATS - 1));
    assign push    = take && last;
    assign pop     = instr_valid && instr_ready && !redirect;
    assign push_pc = (beat == '0) ? mem_adr : start_pc;
    assign mem_req = (state == FETCH);

`ifdef IFA_BIG_ENDIAN_EN
    assign slot = BW'(BEATS - 1) - beat;
`else
    assign slot = beat;
`endif

    always_comb begin
        word_nxt = asm_word;
        word_nxt[slot*MEM_W +: MEM_W] = memdata;
    end

    always_comb begin
        irwrite = '0;
        if (take) irwrite[beat] = 1'b1;
    end

    // Occupancy as it will be after this edge, used to decide whether to start the next word.
    assign cnt_after = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    assign room      = cnt_after < (CW+1)'(DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (count < CW'(DEPTH)) ? FETCH : STALL;
            FETCH:   if (push) state_nxt = room ? FETCH : STALL;
            STALL:   if (count < CW'(DEPTH)) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
        if (redirect) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat     <= '0;
            asm_word <= '0;
            start_pc <= '0;
            mem_adr  <= RESET_PC;
        end else if (redirect) begin
            beat     <= '0;
            asm_word <= '0;
            mem_adr  <= redirect_pc;
        end else if (take) begin
            asm_word <= word_nxt;
            mem_adr  <= mem_adr + STEP;
            beat     <= last ? '0 : beat + 1'b1;
            if (beat == '0) start_pc <= mem_adr;
        end
    end

    ifa_fifo #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .din   ({word_nxt, push_pc}),
        .dout  ({instr, instr_pc}),
        .valid (instr_valid),
        .count (count)
    );

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// Directed bench: default 8-bit-beat instance plus a 16-bit-beat instance with RESET_PC=0xFC.
module tb_instr_fetch_assembler;

`ifdef IFA_BIG_ENDIAN_EN
    localparam logic [31:0] EXP_ADD  = 32'h20084300;
    localparam logic [31:0] EXP_W1   = 32'h11121314;
    localparam logic [31:0] EXP_W40  = 32'h11223344;
    localparam logic [31:0] EXP_BFC  = 32'h12345678;
    localparam logic [31:0] EXP_B00  = 32'hBEEFDEAD;
`else
    localparam logic [31:0] EXP_ADD  = 32'h00430820;
    localparam logic [31:0] EXP_W1   = 32'h14131211;
    localparam logic [31:0] EXP_W40  = 32'h44332211;
    localparam logic [31:0] EXP_BFC  = 32'h56781234;
    localparam logic [31:0] EXP_B00  = 32'hDEADBEEF;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_redir, a_req, a_ack, a_valid, a_ready;
    logic [7:0]  a_rpc, a_adr, a_data, a_pc;
    logic [3:0]  a_irw;
    logic [31:0] a_instr;
    logic [1:0]  a_count;

    logic        b_redir, b_req, b_ack, b_valid, b_ready;
    logic [7:0]  b_rpc, b_adr, b_pc;
    logic [15:0] b_data;
    logic [1:0]  b_irw;
    logic [31:0] b_instr;
    logic [1:0]  b_count;

    instr_fetch_assembler u_dut (
        .clk(clk), .reset(rst_n), .redirect(a_redir), .redirect_pc(a_rpc),
        .mem_req(a_req), .mem_adr(a_adr), .mem_ack(a_ack), .memdata(a_data),
        .irwrite(a_irw), .instr_valid(a_valid), .instr_ready(a_ready),
        .instr(a_instr), .instr_pc(a_pc), .count(a_count)
    );

    instr_fetch_assembler #(.MEM_W(16), .RESET_PC(8'hFC)) u_dut16 (
        .clk(clk), .reset(rst_n), .redirect(b_redir), .redirect_pc(b_rpc),
        .mem_req(b_req), .mem_adr(b_adr), .mem_ack(b_ack), .memdata(b_data),
        .irwrite(b_irw), .instr_valid(b_valid), .instr_ready(b_ready),
        .instr(b_instr), .instr_pc(b_pc), .count(b_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: present one acked beat, check the request side, cross one posedge.
    task automatic beat_a(input logic [7:0] adr, input logic [7:0] data, input logic [3:0] iw);
        a_ack = 1'b1; a_data = data;
        #1;
        check("a_req", a_req, 1);
        check("a_adr", a_adr, adr);
        check("a_irwrite", a_irw, iw);
        @(negedge clk);
    endtask

    task automatic beat_b(input logic [7:0] adr, input logic [15:0] data, input logic [1:0] iw);
        b_ack = 1'b1; b_data = data;
        #1;
        check("b_req", b_req, 1);
        check("b_adr", b_adr, adr);
        check("b_irwrite", b_irw, iw);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        a_redir = 0; a_rpc = '0; a_ack = 0; a_data = '0; a_ready = 0;
        b_redir = 0; b_rpc = '0; b_ack = 0; b_data = '0; b_ready = 0;
        repeat (2) @(negedge clk);

        // T1: reset values, then the fetch starts one cycle after release
        check("rst_req", a_req, 0);
        check("rst_adr", a_adr, 8'h00);
        check("rst_irwrite", a_irw, 0);
        check("rst_valid", a_valid, 0);
        check("rst_instr", a_instr, 0);
        check("rst_pc", a_pc, 0);
        check("rst_count", a_count, 0);
        check("rst_b_adr", b_adr, 8'hFC);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_req", a_req, 1);
        check("t1_adr", a_adr, 8'h00);
        check("t1_valid", a_valid, 0);
        check("t1_count", a_count, 0);

        // T2: add r1,r2,r3 assembled from four byte beats
        beat_a(8'h00, 8'h20, 4'b0001);
        beat_a(8'h01, 8'h08, 4'b0010);
        beat_a(8'h02, 8'h43, 4'b0100);
        check("t2_valid_pre", a_valid, 0);
        beat_a(8'h03, 8'h00, 4'b1000);
        a_ack = 1'b0;
        #1;
        check("t2_valid", a_valid, 1);
        check("t2_instr", a_instr, EXP_ADD);
        check("t2_pc", a_pc, 8'h00);
        check("t2_count", a_count, 1);

        // T3: fill the buffer with no consumer, then release one slot
        beat_a(8'h04, 8'h11, 4'b0001);
        beat_a(8'h05, 8'h12, 4'b0010);
        beat_a(8'h06, 8'h13, 4'b0100);
        beat_a(8'h07, 8'h14, 4'b1000);
        a_ack = 1'b0;
        #1;
        check("t3_count_full", a_count, 2);
        check("t3_req_stall", a_req, 0);
        check("t3_adr_stall", a_adr, 8'h08);
        check("t3_head_held", a_instr, EXP_ADD);
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        #1;
        check("t3_count_pop", a_count, 1);
        check("t3_req_still0", a_req, 0);
        check("t3_head_pc", a_pc, 8'h04);
        check("t3_head_instr", a_instr, EXP_W1);
        @(negedge clk);
        #1;
        check("t3_req_resume", a_req, 1);
        check("t3_adr_resume", a_adr, 8'h08);

        // T4: redirect two beats into a word, with an ack on the redirect edge
        beat_a(8'h08, 8'h55, 4'b0001);
        beat_a(8'h09, 8'h66, 4'b0010);
        a_data = 8'hAA; a_redir = 1'b1; a_rpc = 8'h40;
        @(negedge clk);
        a_redir = 1'b0; a_ack = 1'b0;
        #1;
        check("t4_count", a_count, 0);
        check("t4_valid", a_valid, 0);
        check("t4_req_low", a_req, 0);
        check("t4_adr", a_adr, 8'h40);
        @(negedge clk);
        beat_a(8'h40, 8'h11, 4'b0001);
        beat_a(8'h41, 8'h22, 4'b0010);
        beat_a(8'h42, 8'h33, 4'b0100);
        beat_a(8'h43, 8'h44, 4'b1000);
        a_ack = 1'b0;
        #1;
        check("t4_instr", a_instr, EXP_W40);
        check("t4_pc", a_pc, 8'h40);
        check("t4_count_after", a_count, 1);

        // Reset mid-word: state returns immediately, partial beat is lost
        beat_a(8'h44, 8'h77, 4'b0001);
        rst_n = 1'b0;
        #1;
        check("mrst_req", a_req, 0);
        check("mrst_adr", a_adr, 8'h00);
        check("mrst_count", a_count, 0);
        check("mrst_valid", a_valid, 0);
        a_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat_a(8'h00, 8'h20, 4'b0001);
        a_ack = 1'b0;

        // T5: 16-bit beats from 0xFC, address wraps to 0x00
        beat_b(8'hFC, 16'h1234, 2'b01);
        beat_b(8'hFE, 16'h5678, 2'b10);
        b_ack = 1'b0;
        #1;
        check("t5_pc", b_pc, 8'hFC);
        check("t5_instr", b_instr, EXP_BFC);
        check("t5_count", b_count, 1);
        check("t5_adr_wrap", b_adr, 8'h00);

        // T6: pop and last-beat push on the same edge at count=1
        beat_b(8'h00, 16'hBEEF, 2'b01);
        b_ready = 1'b1;
        beat_b(8'h02, 16'hDEAD, 2'b10);
        b_ready = 1'b0; b_ack = 1'b0;
        #1;
        check("t6_count", b_count, 1);
        check("t6_pc", b_pc, 8'h00);
        check("t6_instr", b_instr, EXP_B00);
        check("t6_req", b_req, 1);
        check("t6_adr", b_adr, 8'h04);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
